// File: rtl/stream_source.sv
// Stream source: accepts a (start, stride, count) command and emits count bytes
// start, start+stride, ... over a valid/ready stream, counting backpressure cycles.
module stream_source #(
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         cmd_start,
  input  logic [7:0]         cmd_stride,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [7:0]         data,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        stall_count
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         stride_q, stride_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [15:0]        stall_q, stall_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    stall_d  = stall_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    ready_d  = ready_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          stall_d = 16'h0000;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          if (cmd_count != '0) begin
            state_d  = SEND;
            data_d   = cmd_start;
            rem_d    = cmd_count;
            stride_d = cmd_stride;
            valid_d  = 1'b1;
          end else begin
            // Empty burst goes straight to the completion pulse.
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      SEND: begin
        if (data_ready) begin
          data_d = data_q + stride_q;
          rem_d  = rem_q - COUNT_W'(1);
          if (rem_q == COUNT_W'(1)) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_q   <= 8'h00;
      stride_q <= 8'h00;
      rem_q    <= '0;
      stall_q  <= 16'h0000;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
      stall_q  <= stall_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign data        = data_q;
  assign data_valid  = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_stream_source.sv
// Bench for stream_source: directed and random bursts checked every cycle against
// a queue-based model of the bytes still owed, the pending done pulse and stalls.
module tb_stream_source;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    cmd_start = '0;
  logic [7:0]    cmd_stride = '0;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    data;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [15:0]   stall_count;

  int total = 0;
  int bad = 0;

  // Model: bytes still to deliver, whether the done pulse is showing, stall total.
  logic [7:0] exp_q[$];
  bit         done_e = 0;
  int         stalls = 0;

  stream_source #(.COUNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .cmd_start(cmd_start), .cmd_stride(cmd_stride), .cmd_count(cmd_count),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit sending;
    sending = (exp_q.size() > 0);
    chk("data_valid", {15'd0, data_valid}, {15'd0, sending});
    chk("done", {15'd0, done}, {15'd0, done_e});
    chk("busy", {15'd0, busy}, {15'd0, sending | done_e});
    chk("cmd_ready", {15'd0, cmd_ready}, {15'd0, !(sending | done_e)});
    chk("stall_count", stall_count, 16'(stalls));
    if (sending) chk("data", {8'd0, data}, {8'd0, exp_q[0]});
  endtask

  // Check the current cycle, drive inputs, predict the edge, advance to next negedge.
  task automatic step(input logic v, input logic [7:0] s, input logic [7:0] st,
                      input logic [CW-1:0] c, input logic r);
    check_outputs();
    cmd_valid = v; cmd_start = s; cmd_stride = st; cmd_count = c; data_ready = r;
    if (done_e) begin
      done_e = 0;
    end else if (exp_q.size() > 0) begin
      if (r) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_e = 1;
      end else if (stalls < 65535) begin
        stalls++;
      end
    end else if (v) begin
      stalls = 0;
      for (int i = 0; i < int'(c); i++) exp_q.push_back(8'(int'(s) + i * int'(st)));
      if (c == 0) done_e = 1;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, '0, r);
  endtask

  initial begin
    // Reset state, checked while reset is held.
    #12;
    chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_data_valid", {15'd0, data_valid}, 16'd0);
    chk("rst_data", {8'd0, data}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_stall", stall_count, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Basic burst 05,0C,13 then done.
    step(1'b1, 8'h05, 8'h07, 8'd3, 1'b1);
    idle(5, 1'b1);

    // Backpressure on the second byte for two cycles.
    step(1'b1, 8'h05, 8'h07, 8'd3, 1'b1);
    step(1'b0, 8'h00, 8'h00, '0, 1'b1);
    step(1'b0, 8'h00, 8'h00, '0, 1'b0);
    step(1'b0, 8'h00, 8'h00, '0, 1'b0);
    idle(4, 1'b1);
    chk("stall_final", stall_count, 16'd2);

    // Wrap-around.
    step(1'b1, 8'hFE, 8'h03, 8'd2, 1'b1);
    idle(4, 1'b1);

    // Empty burst.
    step(1'b1, 8'h55, 8'h01, 8'd0, 1'b1);
    idle(3, 1'b1);

    // Second command held during a burst; taken in the first idle cycle.
    step(1'b1, 8'h10, 8'h01, 8'd3, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h80, 8'h02, 8'd2, (i != 1));
    idle(5, 1'b1);

    // Maximum count.
    step(1'b1, 8'h00, 8'h01, 8'd255, 1'b1);
    idle(260, 1'b1);

    // Asynchronous reset mid-burst after one of three bytes.
    step(1'b1, 8'h05, 8'h07, 8'd3, 1'b1);
    step(1'b0, 8'h00, 8'h00, '0, 1'b0);
    step(1'b0, 8'h00, 8'h00, '0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_data_valid", {15'd0, data_valid}, 16'd0);
    chk("arst_data", {8'd0, data}, 16'h0000);
    chk("arst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    chk("arst_stall", stall_count, 16'h0000);
    @(posedge clock); #1;
    chk("arst_done", {15'd0, done}, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete(); done_e = 0; stalls = 0;
    idle(2, 1'b1);
    step(1'b1, 8'h21, 8'h10, 8'd2, 1'b1);
    idle(4, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [CW-1:0] c;
      c = ($urandom_range(0, 19) == 0) ? CW'(0) : CW'($urandom_range(1, 6));
      step($urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom), c, $urandom_range(0, 3) != 0);
    end
    idle(20, 1'b1);

    // Stall counter saturation.
    step(1'b1, 8'h3C, 8'h01, 8'd1, 1'b0);
    idle(65540, 1'b0);
    chk("stall_sat", stall_count, 16'hFFFF);
    idle(4, 1'b1);
    chk("stall_hold", stall_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
